// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment display scanner with a valid/ready update port.
// Updates land in a pending set and are copied to the active set only at a
// frame boundary, so a frame is always drawn from one consistent set.
module seg_display_scanner #(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_digits,
    input  logic                  load_sign,
    input  logic [N_DIGITS-1:0]   load_dp,
    input  logic [N_DIGITS-1:0]   load_blink,
    input  logic                  load_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int unsigned DIV_W = $clog2(DIGIT_CYCLES);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned BLK_W = $clog2(BLINK_CYCLES);
    localparam int unsigned DIG_W = 4 * N_DIGITS;
    localparam int          TOP_I = int'(N_DIGITS) - 1;

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [6:0]          SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF   = ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // Patterns below are active-low, bit 6 = g .. bit 0 = a.
    localparam logic [6:0] PAT_MINUS = 7'b0111111;
    localparam logic [6:0] PAT_BLANK = 7'b1111111;

    // Scan and blink timing
    logic [DIV_W-1:0] r_div;
    logic [IDX_W-1:0] r_scan;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    // Pending (staged) and active (displayed) display sets
    logic [DIG_W-1:0]    r_pnd_digits, r_act_digits;
    logic                r_pnd_sign,   r_act_sign;
    logic [N_DIGITS-1:0] r_pnd_dp,     r_act_dp;
    logic [N_DIGITS-1:0] r_pnd_blink,  r_act_blink;
    logic                r_pnd_lz,     r_act_lz;
    logic                r_pend_flag;
    logic                r_ready;

    // Registered outputs
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [N_DIGITS-1:0] r_an;
    logic                r_frame_start;

    logic                w_boundary;
    logic                w_accept;
    logic                w_commit;
    logic                w_pend_nxt;
    logic [N_DIGITS-1:0] w_sup;
    logic                w_run;
    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_blk_bit;
    logic                w_sup_bit;
    logic [N_DIGITS-1:0] w_onehot;
    logic                w_is_sign;
    logic                w_blank;
    logic [6:0]          w_pat;
    logic                w_dp_lit;
    logic [6:0]          w_seg_c;
    logic                w_dp_c;
    logic [N_DIGITS-1:0] w_an_c;

    assign load_ready  = r_ready;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = r_frame_start;

    // Hex nibble to active-low g..a pattern
    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'b1000000;
            4'h1:    p = 7'b1111001;
            4'h2:    p = 7'b0100100;
            4'h3:    p = 7'b0110000;
            4'h4:    p = 7'b0011001;
            4'h5:    p = 7'b0010010;
            4'h6:    p = 7'b0000010;
            4'h7:    p = 7'b1111000;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0010000;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b0000011;
            4'hC:    p = 7'b1000110;
            4'hD:    p = 7'b0100001;
            4'hE:    p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    assign w_boundary = (r_div == DIV_LAST) && (r_scan == IDX_LAST);
    assign w_accept   = load_valid && r_ready;
    assign w_commit   = w_boundary && r_pend_flag;
    assign w_pend_nxt = w_accept || (r_pend_flag && !w_commit);

    // Digit dwell divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_scan <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_scan <= (r_scan == IDX_LAST) ? '0 : r_scan + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Free-running blink half-period counter, independent of the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= !r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
        end
    end

    // Update handshake: stage on accept, publish only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pnd_digits <= '0;
            r_pnd_sign   <= 1'b0;
            r_pnd_dp     <= '0;
            r_pnd_blink  <= '0;
            r_pnd_lz     <= 1'b0;
            r_act_digits <= '0;
            r_act_sign   <= 1'b0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_act_lz     <= 1'b0;
            r_pend_flag  <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_act_digits <= r_pnd_digits;
                r_act_sign   <= r_pnd_sign;
                r_act_dp     <= r_pnd_dp;
                r_act_blink  <= r_pnd_blink;
                r_act_lz     <= r_pnd_lz;
            end
            // Accept and commit are exclusive: ready is low whenever a set is pending.
            if (w_accept) begin
                r_pnd_digits <= load_digits;
                r_pnd_sign   <= load_sign;
                r_pnd_dp     <= load_dp;
                r_pnd_blink  <= load_blink;
                r_pnd_lz     <= load_lz;
            end
            r_pend_flag <= w_pend_nxt;
            r_ready     <= !w_pend_nxt;
        end
    end

    // Leading-zero suppression mask, scanning down from the top numeric digit
    always_comb begin
        w_sup = '0;
        w_run = 1'b1;
        for (int i = TOP_I; i >= 1; i--) begin
            if (!(r_act_sign && (i == TOP_I))) begin
                w_run    = w_run && (r_act_digits[i*4 +: 4] == 4'h0);
                w_sup[i] = r_act_lz && w_run;
            end
        end
    end

    // Select the attributes of the digit currently being scanned
    always_comb begin
        w_nib     = 4'h0;
        w_dp_bit  = 1'b0;
        w_blk_bit = 1'b0;
        w_sup_bit = 1'b0;
        w_onehot  = '0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (r_scan == IDX_W'(i)) begin
                w_nib       = r_act_digits[i*4 +: 4];
                w_dp_bit    = r_act_dp[i];
                w_blk_bit   = r_act_blink[i];
                w_sup_bit   = w_sup[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // Segment, decimal-point and anode values for the scanned digit
    always_comb begin
        w_is_sign = r_act_sign && (r_scan == IDX_LAST);
        w_blank   = w_sup_bit || (r_blink_phase && w_blk_bit);
        if (w_blank) begin
            w_pat = PAT_BLANK;
        end else if (w_is_sign) begin
            w_pat = PAT_MINUS;
        end else begin
            w_pat = f_hex7(w_nib);
        end
        w_dp_lit = w_dp_bit && !w_blank;
        w_seg_c  = ACTIVE_LOW ? w_pat : ~w_pat;
        w_dp_c   = ACTIVE_LOW ? !w_dp_lit : w_dp_lit;
        w_an_c   = ACTIVE_LOW ? ~w_onehot : w_onehot;
    end

    // Output registers; frame_start marks the first registered digit-0 cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg         <= SEG_OFF;
            r_dp          <= DP_OFF;
            r_an          <= AN_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_c;
            r_dp          <= w_dp_c;
            r_an          <= w_an_c;
            r_frame_start <= (r_div == '0) && (r_scan == '0);
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (4 digits, 4-cycle dwell,
// 64-cycle blink half-period, active-low). Accepted updates are pushed to a
// scoreboard queue and popped when the frame that should show them starts.
module tb_seg_display_scanner;

    localparam int N  = 4;
    localparam int DC = 4;
    localparam int BC = 64;
    localparam int FR = N * DC;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_digits;
    logic          load_sign;
    logic [3:0]    load_dp;
    logic [3:0]    load_blink;
    logic          load_lz;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    seg_display_scanner #(
        .N_DIGITS    (N),
        .DIGIT_CYCLES(DC),
        .BLINK_CYCLES(BC),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_digits(load_digits),
        .load_sign  (load_sign),
        .load_dp    (load_dp),
        .load_blink (load_blink),
        .load_lz    (load_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      supp;
        logic [3:0]      dpm;
        logic [3:0]      blk;
        int              acc;
    } ent_t;

    ent_t exp_q[$];
    ent_t cur;
    int   n_checks = 0;
    int   n_err    = 0;
    int   k        = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, want);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Expected frame content for a committed update (acc = accepting edge number)
    function automatic ent_t mk(input logic [15:0] dg, input logic sg, input logic [3:0] dpm,
                                input logic [3:0] blk, input logic lz, input int acc);
        ent_t e;
        bit   allz;
        int   top;
        e.dpm  = dpm;
        e.blk  = blk;
        e.acc  = acc;
        e.supp = 4'h0;
        for (int i = 0; i < N; i++) e.seg[i] = seg_of(dg[i*4 +: 4]);
        if (sg) e.seg[3] = 7'b0111111;
        top = sg ? 3 : 4;
        if (lz) begin
            for (int i = 1; i < top; i++) begin
                allz = 1'b1;
                for (int j = i; j < top; j++) if (dg[j*4 +: 4] != 4'h0) allz = 1'b0;
                if (allz) begin
                    e.supp[i] = 1'b1;
                    e.seg[i]  = 7'b1111111;
                end
            end
        end
        return e;
    endfunction

    // Count clock edges since reset release
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Per-cycle output monitor driven by the scoreboard's current frame
    always @(negedge clk) begin
        int         d;
        bit         ph;
        bit         fs;
        bit         blank;
        logic [3:0] ea;
        if (mon_en) begin
            if (k == 0) begin
                cur = mk(16'h0000, 1'b0, 4'h0, 4'h0, 1'b0, 0);
                chk("rst_seg",   32'(seg),         32'h7F);
                chk("rst_dp",    32'(dp),          32'h1);
                chk("rst_an",    32'(an),          32'hF);
                chk("rst_fs",    32'(frame_start), 32'h0);
                chk("rst_ready", 32'(load_ready),  32'h0);
            end else begin
                d  = ((k - 1) / DC) % N;
                ph = (((k - 1) / BC) % 2) == 1;
                fs = ((k - 1) % FR) == 0;
                if (fs && exp_q.size() > 0) begin
                    if (exp_q[0].acc < k - 1) cur = exp_q.pop_front();
                end
                blank = cur.supp[d] || (ph && cur.blk[d]);
                ea    = 4'hF;
                ea[d] = 1'b0;
                chk("an",  32'(an),          32'(ea));
                chk("seg", 32'(seg),         blank ? 32'h7F : 32'(cur.seg[d]));
                chk("dp",  32'(dp),          (cur.dpm[d] && !blank) ? 32'h0 : 32'h1);
                chk("fs",  32'(frame_start), 32'(fs));
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Advance to the negedge where the frame position (k-1)%FR equals p
    task automatic wait_pos(input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FR && !hit; i++) begin
            @(negedge clk);
            if (k >= 1 && ((k - 1) % FR) == p) hit = 1'b1;
        end
        chk("wait_pos_timeout", 32'(hit), 32'h1);
    endtask

    task automatic do_load(input logic [15:0] dg, input logic sg, input logic [3:0] dpm,
                           input logic [3:0] blk, input logic lz);
        bit done = 1'b0;
        load_digits = dg;
        load_sign   = sg;
        load_dp     = dpm;
        load_blink  = blk;
        load_lz     = lz;
        load_valid  = 1'b1;
        for (int i = 0; i < 4 * FR && !done; i++) begin
            if (load_ready) begin
                exp_q.push_back(mk(dg, sg, dpm, blk, lz, k + 1));
                done = 1'b1;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("accept_timeout",     32'(done),       32'h1);
        chk("ready_after_accept", 32'(load_ready), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_digits = 16'h0;
        load_sign   = 1'b0;
        load_dp     = 4'h0;
        load_blink  = 4'h0;
        load_lz     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        cycles(2);
        rst = 1'b0;

        // Idle scan after reset: all digits show zero
        cycles(3);
        chk("ready_idle", 32'(load_ready), 32'h1);
        cycles(40);

        // Mid-frame load with leading-zero suppression
        wait_pos(5);
        do_load(16'h0A53, 1'b0, 4'h0, 4'h0, 1'b1);
        wait_pos(1);
        chk("ready_after_commit", 32'(load_ready), 32'h1);
        cycles(2 * FR);

        // Sign digit with suppression of the zeros beneath it
        wait_pos(7);
        do_load(16'h0007, 1'b1, 4'h0, 4'h0, 1'b1);
        cycles(3 * FR);

        // Blink on digit 1, decimal point on digit 0
        wait_pos(3);
        do_load(16'h1234, 1'b0, 4'b0001, 4'b0010, 1'b0);
        cycles(300);

        // Valid held high with changing data: one accept per boundary
        wait_pos(1);
        n_acc      = 0;
        load_sign  = 1'b0;
        load_dp    = 4'h0;
        load_blink = 4'h0;
        load_lz    = 1'b0;
        load_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            load_digits = 16'h1000 + 16'(c);
            if (load_ready) begin
                exp_q.push_back(mk(load_digits, 1'b0, 4'h0, 4'h0, 1'b0, k + 1));
                n_acc++;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        chk("hold_accepts", 32'(n_acc), 32'd3);
        cycles(3 * FR);

        // Reset with an update pending: it must never be displayed
        wait_pos(4);
        do_load(16'h8888, 1'b0, 4'hF, 4'h0, 1'b0);
        cycles(2);
        rst = 1'b1;
        exp_q.delete();
        cycles(3);
        rst = 1'b0;
        cycles(3);
        chk("ready_post_rst", 32'(load_ready), 32'h1);
        cycles(3 * FR);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
